multi_tick_gen: RTL and testbench

Parametrised multi-channel enable-pulse generator, the successor to the single-rate clk_divider / gen_eninput_pulse pair. A shared prescaler derives a base tick from the system clock, and NUM_CH independent channels divide that tick by runtime-loadable divisors. Each channel emits single-cycle `en_pulse` strobes plus a 50%-duty square wave, with continuous or one-shot mode. It feeds input-sampling, counter-advance and display-refresh enables across the LED7seg/HC595 datapath.

---
 rtl/multi_tick_gen_if.sv | 29 ++
 rtl/multi_tick_gen.sv | 119 +++++++++++
 tb/tb_multi_tick_gen.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/multi_tick_gen_if.sv
// multi_tick_gen_if: control/status bundle for multi_tick_gen.
//   master : drives ch_en, oneshot, load, load_ch, load_val, sync
//            and observes base_tick, en_pulse, square
//   slave  : the generator side of the same signals
interface multi_tick_gen_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 16,
  parameter int LCH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] oneshot;
  logic              load;
  logic [LCH_W-1:0]  load_ch;
  logic [DIV_W-1:0]  load_val;
  logic              sync;
  logic              base_tick;
  logic [NUM_CH-1:0] en_pulse;
  logic [NUM_CH-1:0] square;

  modport master (
    output ch_en, oneshot, load, load_ch, load_val, sync,
    input  base_tick, en_pulse, square
  );

  modport slave (
    input  ch_en, oneshot, load, load_ch, load_val, sync,
    output base_tick, en_pulse, square
  );
endinterface

// File: rtl/multi_tick_gen.sv
// multi_tick_gen: shared prescaler producing base_tick, plus NUM_CH
// independent divider channels, each emitting a one-cycle en_pulse and
// a 50%-duty square wave, in continuous or one-shot mode.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : multi_tick_gen_if.slave (controls in, strobes/squares out)

// One divider channel.
//   base_tick/ch_en/oneshot : advance qualifiers and mode
//   load_hit/load_val       : divisor write addressed to this channel
//   sync                    : global phase realign
//   en_pulse/square         : registered outputs
module multi_tick_ch #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             base_tick,
  input  logic             ch_en,
  input  logic             oneshot,
  input  logic             load_hit,
  input  logic [DIV_W-1:0] load_val,
  input  logic             sync,
  output logic             en_pulse,
  output logic             square
);
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] cnt;
  logic             armed;
  logic             adv;

  // div==0 parks the channel: never advances, cnt holds.
  assign adv = base_tick && ch_en && armed && (div != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      div      <= DIV_W'(DEFAULT_DIV);
      cnt      <= '0;
      armed    <= 1'b1;
      en_pulse <= 1'b0;
      square   <= 1'b0;
    end else begin
      en_pulse <= 1'b0;
      // Load/sync take priority over a same-cycle terminal count.
      if (load_hit || sync) begin
        if (load_hit) div <= load_val;
        cnt   <= '0;
        armed <= 1'b1;
        if (sync) square <= 1'b0;
      end else if (adv) begin
        if (cnt == div - DIV_W'(1)) begin
          cnt      <= '0;
          en_pulse <= 1'b1;
          square   <= ~square;
          if (oneshot) armed <= 1'b0;
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
    end
  end
endmodule

module multi_tick_gen #(
  parameter int INPUT_CLK_FREQ = 100_000_000,
  parameter int BASE_TICK_FREQ = 10_000,
  parameter int NUM_CH         = 4,
  parameter int DIV_W          = 16,
  parameter int DEFAULT_DIV    = 1000
) (
  input logic              clk,
  input logic              rst,
  multi_tick_gen_if.slave  bus
);
  localparam int PRESCALE = INPUT_CLK_FREQ / BASE_TICK_FREQ;
  localparam int PRE_W    = $clog2(PRESCALE);
  localparam int LCH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PRE_W-1:0]  pre_cnt;
  logic              base_tick;
  logic [NUM_CH-1:0] en_pulse;
  logic [NUM_CH-1:0] square;

  // Sync zeroes the prescaler and suppresses the tick computed at that
  // edge, so the next base_tick lands exactly PRESCALE cycles later.
  always_ff @(posedge clk) begin
    if (rst || bus.sync) begin
      pre_cnt   <= '0;
      base_tick <= 1'b0;
    end else begin
      base_tick <= (pre_cnt == PRE_W'(PRESCALE - 1));
      pre_cnt   <= (pre_cnt == PRE_W'(PRESCALE - 1)) ? '0 : pre_cnt + PRE_W'(1);
    end
  end

  // Per-channel address decode; an out-of-range load_ch matches no lane.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    multi_tick_ch #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .base_tick (base_tick),
      .ch_en     (bus.ch_en[i]),
      .oneshot   (bus.oneshot[i]),
      .load_hit  (bus.load && (bus.load_ch == LCH_W'(i))),
      .load_val  (bus.load_val),
      .sync      (bus.sync),
      .en_pulse  (en_pulse[i]),
      .square    (square[i])
    );
  end

  assign bus.base_tick = base_tick;
  assign bus.en_pulse  = en_pulse;
  assign bus.square    = square;
endmodule

// File: tb/tb_multi_tick_gen.sv
module tb_multi_tick_gen;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc;
  int   checks = 0;
  int   errors = 0;

  typedef struct { int c; logic [NCH-1:0] m; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Cycle 1 is the first edge with rst low.
  always @(posedge clk) if (rst) cyc <= 0; else cyc <= cyc + 1;

  multi_tick_gen_if #(.NUM_CH(NCH), .DIV_W(8)) bus ();

  multi_tick_gen #(
    .INPUT_CLK_FREQ (100),
    .BASE_TICK_FREQ (10),
    .NUM_CH         (NCH),
    .DIV_W          (8),
    .DEFAULT_DIV    (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic void push(int c, logic [NCH-1:0] m);
    sb.push_back('{c, m});
  endfunction

  // Advance one cycle, sample #1 after the edge, pop expected pulse mask.
  task automatic tick(output logic [NCH-1:0] e);
    @(posedge clk); #1;
    e = '0;
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].c == cyc) begin e |= sb[i].m; sb.delete(i); end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ch_en = '1; bus.oneshot = '0; bus.load = 1'b0;
    bus.load_ch = '0; bus.load_val = '0; bus.sync = 1'b0;
    sb.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [NCH-1:0] e;
    rst = 1'b1; bus.load = 1'b1; bus.sync = 1'b1; bus.load_val = 8'd9;
    bus.ch_en = '1; bus.oneshot = '0; bus.load_ch = '0;
    sb.delete();
    repeat (2) tick(e);
    checks += 3;
    if (bus.base_tick !== 1'b0) begin errors++; $display("FAIL reset_base_tick got=%b exp=0", bus.base_tick); end
    if (bus.en_pulse !== e)     begin errors++; $display("FAIL reset_en_pulse got=%b exp=%b", bus.en_pulse, e); end
    if (bus.square !== 4'h0)    begin errors++; $display("FAIL reset_square got=%b exp=0000", bus.square); end
  endtask

  task automatic test_continuous();
    logic [NCH-1:0] e, sq;
    logic bt;
    do_reset();
    push(31, 4'hF); push(61, 4'hF);
    for (int n = 0; n < 70; n++) begin
      tick(e);
      bt = (cyc % 10 == 0);
      sq = (cyc >= 31 && cyc < 61) ? 4'hF : 4'h0;
      checks += 3;
      if (bus.base_tick !== bt) begin errors++; $display("FAIL cont_base_tick cyc=%0d got=%b exp=%b", cyc, bus.base_tick, bt); end
      if (bus.en_pulse !== e)   begin errors++; $display("FAIL cont_pulse cyc=%0d got=%b exp=%b", cyc, bus.en_pulse, e); end
      if (bus.square !== sq)    begin errors++; $display("FAIL cont_square cyc=%0d got=%b exp=%b", cyc, bus.square, sq); end
    end
  endtask

  task automatic test_load();
    logic [NCH-1:0] e;
    do_reset();
    bus.load = 1'b1; bus.load_ch = 2'd1; bus.load_val = 8'd1;
    for (int k = 1; k <= 10; k++) push(k * 10 + 1, 4'b0010);
    push(31, 4'b0001); push(61, 4'b0001); push(91, 4'b0001);
    push(51, 4'b1000); push(101, 4'b1000);
    for (int n = 0; n < 105; n++) begin
      tick(e);
      checks++;
      if (bus.en_pulse !== e) begin errors++; $display("FAIL load_pulse cyc=%0d got=%b exp=%b", cyc, bus.en_pulse, e); end
      case (cyc)
        1: begin bus.load_ch = 2'd2; bus.load_val = 8'd0; end
        2: begin bus.load_ch = 2'd3; bus.load_val = 8'd5; end
        3: bus.load = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_oneshot();
    logic [NCH-1:0] e;
    do_reset();
    bus.oneshot = 4'b0001;
    push(31, 4'hF); push(61, 4'hE); push(91, 4'hE);
    push(101, 4'h1); push(121, 4'hE); push(131, 4'h1);
    for (int n = 0; n < 135; n++) begin
      tick(e);
      checks++;
      if (bus.en_pulse !== e) begin errors++; $display("FAIL oneshot_pulse cyc=%0d got=%b exp=%b", cyc, bus.en_pulse, e); end
      case (cyc)
        40: bus.oneshot = 4'b0000;   // disarmed channel must stay silent
        74: begin bus.load = 1'b1; bus.load_ch = 2'd0; bus.load_val = 8'd3; end
        75: bus.load = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_ch_en();
    logic [NCH-1:0] e;
    do_reset();
    push(31, 4'b1011); push(51, 4'b0100); push(61, 4'b1011);
    push(81, 4'b0100); push(91, 4'b1011);
    for (int n = 0; n < 95; n++) begin
      tick(e);
      checks++;
      if (bus.en_pulse !== e) begin errors++; $display("FAIL ch_en_pulse cyc=%0d got=%b exp=%b", cyc, bus.en_pulse, e); end
      case (cyc)
        15: bus.ch_en = 4'b1011;
        35: bus.ch_en = 4'b1111;
        default: ;
      endcase
    end
  endtask

  task automatic test_load_sync();
    logic [NCH-1:0] e, sq;
    logic bt;
    do_reset();
    push(31, 4'b1110);
    push(66, 4'b0010); push(76, 4'b1101); push(86, 4'b0010); push(106, 4'hF);
    for (int n = 0; n < 110; n++) begin
      tick(e);
      bt = (cyc <= 45) ? (cyc % 10 == 0) : ((cyc - 45) % 10 == 0);
      sq = '0;
      if (cyc >= 31 && cyc < 45) sq = 4'b1110;
      if (cyc >= 76 && cyc < 106) sq |= 4'b1101;
      if ((cyc >= 66 && cyc < 86) || cyc >= 106) sq |= 4'b0010;
      checks += 3;
      if (bus.en_pulse !== e)   begin errors++; $display("FAIL ls_pulse cyc=%0d got=%b exp=%b", cyc, bus.en_pulse, e); end
      if (bus.base_tick !== bt) begin errors++; $display("FAIL ls_base_tick cyc=%0d got=%b exp=%b", cyc, bus.base_tick, bt); end
      if (bus.square !== sq)    begin errors++; $display("FAIL ls_square cyc=%0d got=%b exp=%b", cyc, bus.square, sq); end
      case (cyc)
        30: begin bus.load = 1'b1; bus.load_ch = 2'd0; bus.load_val = 8'd3; end
        31: bus.load = 1'b0;
        44: begin bus.sync = 1'b1; bus.load = 1'b1; bus.load_ch = 2'd1; bus.load_val = 8'd2; end
        45: begin bus.sync = 1'b0; bus.load = 1'b0; end
        default: ;
      endcase
    end
  endtask

  task automatic test_rst_mid();
    logic [NCH-1:0] e;
    do_reset();
    push(31, 4'hF);
    for (int n = 0; n < 31; n++) begin
      tick(e);
      checks++;
      if (bus.en_pulse !== e) begin errors++; $display("FAIL rm_pre_pulse cyc=%0d got=%b exp=%b", cyc, bus.en_pulse, e); end
    end
    checks++;
    if (bus.square !== 4'hF) begin errors++; $display("FAIL rm_square_high got=%b exp=1111", bus.square); end
    rst = 1'b1; bus.load = 1'b1; bus.load_ch = 2'd0; bus.load_val = 8'd7; bus.sync = 1'b1;
    tick(e);
    checks += 3;
    if (bus.en_pulse !== 4'h0)  begin errors++; $display("FAIL rm_en_pulse got=%b exp=0000", bus.en_pulse); end
    if (bus.square !== 4'h0)    begin errors++; $display("FAIL rm_square got=%b exp=0000", bus.square); end
    if (bus.base_tick !== 1'b0) begin errors++; $display("FAIL rm_base_tick got=%b exp=0", bus.base_tick); end
    rst = 1'b0; bus.load = 1'b0; bus.sync = 1'b0;
    push(31, 4'hF);
    for (int n = 0; n < 35; n++) begin
      tick(e);
      checks++;
      if (bus.en_pulse !== e) begin errors++; $display("FAIL rm_post_pulse cyc=%0d got=%b exp=%b", cyc, bus.en_pulse, e); end
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_load();
    test_oneshot();
    test_ch_en();
    test_load_sync();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
